// File: rtl/biquad_mac_sched.sv
// Time-multiplexed biquad engine: one shared multiplier and accumulator
// step through b0*x, b1*x1, b2*x2, a1*y1, a2*y2 for NCH channels.
module biquad_mac_sched #(
    parameter int WD    = 16,
    parameter int WC    = 10,
    parameter int NCH   = 2,
    parameter int CHW   = $clog2(NCH),
    parameter int ACC_W = 29
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WD-1:0]  in_data,
    input  logic [CHW-1:0] in_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WD-1:0]  out_data,
    output logic [CHW-1:0] out_ch,
    output logic           ovf,
    input  logic           coef_we,
    input  logic [2:0]     coef_addr,
    input  logic [WC-1:0]  coef_wdata,
    output logic           coef_err,
    output logic           busy
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

    localparam int PW = WD + WC;
    localparam int RW = ACC_W - 7;

    state_t r_state, w_next;

    logic [2:0]              r_step;
    logic signed [WD-1:0]    r_x;
    logic [CHW-1:0]          r_ch;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [WC-1:0]    r_coef [5];
    logic signed [WD-1:0]    r_x1 [NCH];
    logic signed [WD-1:0]    r_x2 [NCH];
    logic signed [WD-1:0]    r_y1 [NCH];
    logic signed [WD-1:0]    r_y2 [NCH];
    logic [WD-1:0]           r_out_data;
    logic [CHW-1:0]          r_out_ch;
    logic                    r_out_valid;
    logic                    r_ovf;
    logic                    r_coef_err;

    logic signed [WD-1:0]    w_dop;
    logic signed [WC-1:0]    w_cop;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic [RW-1:0]           w_r;
    logic [RW-WD:0]          w_hi;
    logic                    w_clip;
    logic [WD-1:0]           w_y;

    always_comb begin
        w_dop = r_x;
        w_cop = r_coef[0];
        unique case (r_step)
            3'd1: begin w_dop = r_x1[r_ch]; w_cop = r_coef[1]; end
            3'd2: begin w_dop = r_x2[r_ch]; w_cop = r_coef[2]; end
            3'd3: begin w_dop = r_y1[r_ch]; w_cop = r_coef[3]; end
            3'd4: begin w_dop = r_y2[r_ch]; w_cop = r_coef[4]; end
            default: ;
        endcase
    end

    assign w_prod     = w_dop * w_cop;
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

    // (acc + 128) >>> 8 == floor(acc / 256) + acc[7]
    assign w_r    = {r_acc[ACC_W-1], r_acc[ACC_W-1:8]}
                  + {{(RW-1){1'b0}}, r_acc[7]};
    assign w_hi   = w_r[RW-1:WD-1];
    assign w_clip = !((&w_hi) || !(|w_hi));
    assign w_y    = w_clip ? {w_r[RW-1], {(WD-1){~w_r[RW-1]}}}
                           : w_r[WD-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)     w_next = S_MAC;
            S_MAC:   if (r_step == 3'd4) w_next = S_ROUND;
            S_ROUND: w_next = S_OUT;
            S_OUT:   if (out_ready)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step      <= '0;
            r_x         <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_coef_err  <= 1'b0;
            r_coef[0]   <= WC'(256);
            for (int i = 1; i < 5; i++) r_coef[i] <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_x1[c] <= '0;
                r_x2[c] <= '0;
                r_y1[c] <= '0;
                r_y2[c] <= '0;
            end
        end else begin
            r_coef_err <= 1'b0;
            if (coef_we) begin
                if (r_state == S_IDLE && coef_addr < 3'd5)
                    r_coef[coef_addr] <= coef_wdata;
                else
                    r_coef_err <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_x    <= in_data;
                    r_ch   <= in_ch;
                    r_step <= '0;
                end
                S_MAC: begin
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd0)      r_acc <= w_prod_ext;
                    else if (r_step < 3'd3)  r_acc <= r_acc + w_prod_ext;
                    else                     r_acc <= r_acc - w_prod_ext;
                end
                S_ROUND: begin
                    r_out_data  <= w_y;
                    r_out_ch    <= r_ch;
                    r_ovf       <= w_clip;
                    r_out_valid <= 1'b1;
                    r_x2[r_ch]  <= r_x1[r_ch];
                    r_x1[r_ch]  <= r_x;
                    r_y2[r_ch]  <= r_y1[r_ch];
                    r_y1[r_ch]  <= w_y;
                end
                S_OUT: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign ovf       = r_ovf;
    assign coef_err  = r_coef_err;

endmodule

// File: tb/tb_biquad_mac_sched.sv
// Directed vector bench for biquad_mac_sched: table of samples plus
// hand sequences for backpressure, coefficient errors and reset abort.
module tb_biquad_mac_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [0:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [0:0]  out_ch;
    logic        ovf;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [9:0]  coef_wdata;
    logic        coef_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    biquad_mac_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .ovf        (ovf),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        bit         prog;
        logic [9:0] c0, c1, c2, c3, c4;
        logic [0:0] ch;
        logic [15:0] x;
        logic [15:0] y;
        bit         ov;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wcoef(input logic [2:0] a, input logic [9:0] d);
        wait_idle();
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic prog5(input logic [9:0] c0, c1, c2, c3, c4);
        wcoef(3'd0, c0);
        wcoef(3'd1, c1);
        wcoef(3'd2, c2);
        wcoef(3'd3, c3);
        wcoef(3'd4, c4);
    endtask

    task automatic accept(input logic [0:0] ch, input logic [15:0] x);
        wait_idle();
        in_valid = 1'b1;
        in_data  = x;
        in_ch    = ch;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int start, output logic [15:0] y,
                           output logic [0:0] oc, output logic ov,
                           output int lat);
        lat = 99;
        for (int i = start + 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        y  = out_data;
        oc = out_ch;
        ov = ovf;
    endtask

    logic [15:0] y;
    logic [0:0]  oc;
    logic        ov;
    int          lat;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_ch      = '0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;

        vecs[0] = '{1, 0, 10'h100, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b0, 16'h4000, 16'h4000, 0};
        vecs[1] = '{1, 1, 10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E,
                    1'b0, 16'h1000, 16'h1000, 0};
        vecs[2] = '{0, 0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b0, 16'h0000, 16'h3120, 0};
        vecs[3] = '{1, 1, 10'h1FF, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b0, 16'h7FFF, 16'h7FFF, 1};
        vecs[4] = '{0, 0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b0, 16'h8000, 16'h8000, 1};
        vecs[5] = '{1, 1, 10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E,
                    1'b0, 16'h1000, 16'h1000, 0};
        vecs[6] = '{0, 0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b1, 16'h0000, 16'h0000, 0};
        vecs[7] = '{0, 0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b0, 16'h0000, 16'h3120, 0};
        vecs[8] = '{0, 0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0,
                    1'b1, 16'h1000, 16'h1000, 0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_coef_err",  32'(coef_err),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst_first) do_reset();
            if (vecs[v].prog)
                prog5(vecs[v].c0, vecs[v].c1, vecs[v].c2,
                      vecs[v].c3, vecs[v].c4);
            accept(vecs[v].ch, vecs[v].x);
            collect(0, y, oc, ov, lat);
            chk($sformatf("vec%0d_data", v), 32'(y),   32'(vecs[v].y));
            chk($sformatf("vec%0d_ch", v),   32'(oc),  32'(vecs[v].ch));
            chk($sformatf("vec%0d_ovf", v),  32'(ov),  32'(vecs[v].ov));
            chk($sformatf("vec%0d_lat", v),  32'(lat), 32'd6);
        end

        // Backpressure: result held while out_ready is low
        do_reset();
        out_ready = 1'b0;
        accept(1'b1, 16'h4000);
        collect(0, y, oc, ov, lat);
        chk("bp_data", 32'(y),   32'h4000);
        chk("bp_lat",  32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data",  32'(out_data),  32'h4000);
            chk("bp_hold_ch",    32'(out_ch),    32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Coefficient write during MAC is dropped
        do_reset();
        accept(1'b0, 16'h2000);
        coef_we    = 1'b1;
        coef_addr  = 3'd0;
        coef_wdata = 10'h1FF;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("mac_we_err",  32'(coef_err), 32'd1);
        @(posedge clk); #1;
        chk("mac_we_err_clr", 32'(coef_err), 32'd0);
        collect(2, y, oc, ov, lat);
        chk("mac_we_data", 32'(y),   32'h2000);
        chk("mac_we_lat",  32'(lat), 32'd6);

        // Bad address in IDLE is dropped too
        wcoef(3'd5, 10'h3FF);
        chk("bad_addr_err", 32'(coef_err), 32'd1);
        @(posedge clk); #1;
        chk("bad_addr_err_clr", 32'(coef_err), 32'd0);
        accept(1'b1, 16'h2000);
        collect(0, y, oc, ov, lat);
        chk("bad_addr_data", 32'(y), 32'h2000);

        // Reset during the third MAC cycle aborts the computation
        do_reset();
        prog5(10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E);
        accept(1'b0, 16'h1000);
        collect(0, y, oc, ov, lat);
        chk("abort_pre_data", 32'(y), 32'h1000);
        accept(1'b0, 16'h0000);
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_busy_clr",  32'(busy),      32'd0);
        chk("abort_out_data",  32'(out_data),  32'd0);
        accept(1'b0, 16'h4000);
        collect(0, y, oc, ov, lat);
        chk("abort_post_data", 32'(y),   32'h4000);
        chk("abort_post_ovf",  32'(ov),  32'd0);
        chk("abort_post_lat",  32'(lat), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
